// File: rtl/mux16_word_serializer_pkg.sv
// Shared constants and state encoding for the 16-bit word serializer.
// The PARITY state is only reachable when MUX16_SER_PARITY_EN is defined.
package mux16_word_serializer_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned SEL_W    = 4;
  localparam logic [3:0]  LAST_IDX = 4'd15;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t SHIFT  = 2'd1;
  localparam state_t PARITY = 2'd2;

endpackage

// File: rtl/mux16to1.sv
// 16-to-1 bit-select mux: returns bit sel of d.
module mux16to1 (
  input  logic [15:0] d,
  input  logic [3:0]  sel,
  output logic        y
);

  assign y = d[sel];

endmodule

// File: rtl/mux16_word_serializer.sv
// Parallel word to 16-beat serial stream through a 16:1 bit-select mux.
// Define MUX16_SER_PARITY_EN to append a 17th even-parity beat to every frame.
module mux16_word_serializer #(
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned WORD_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_data,
  output logic              ser_first,
  output logic              ser_last,
  output logic              busy
);

  import mux16_word_serializer_pkg::*;

  if (WORD_W != mux16_word_serializer_pkg::WORD_W) begin : g_bad_width
    $error("mux16_word_serializer: WORD_W must be 16 to match the 16:1 mux");
  end

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [SEL_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel;
  logic               active_q;
  logic               mux_y;
  logic               xfer;
  logic               load;

  assign sel = MSB_FIRST ? ~cnt_q : cnt_q;

  mux16to1 u_mux (
    .d   (word_q),
    .sel (sel),
    .y   (mux_y)
  );

  assign ser_valid = (state_q != IDLE);
  assign busy      = ser_valid;
  assign ser_first = (state_q == SHIFT) && (cnt_q == '0);

`ifdef MUX16_SER_PARITY_EN
  assign ser_last  = (state_q == PARITY);
  assign ser_data  = (state_q == PARITY) ? ^word_q : (ser_valid & mux_y);
`else
  assign ser_last  = (state_q == SHIFT) && (cnt_q == LAST_IDX);
  assign ser_data  = ser_valid & mux_y;
`endif

  // active_q keeps in_ready low until the first clock edge after reset release.
  assign xfer     = ser_valid & ser_ready;
  assign in_ready = active_q & ((state_q == IDLE) | (xfer & ser_last));
  assign load     = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (load) state_d = SHIFT;
      end
      SHIFT: begin
        if (xfer) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_IDX) begin
`ifdef MUX16_SER_PARITY_EN
            state_d = PARITY;
`else
            state_d = load ? SHIFT : IDLE;
`endif
          end
        end
      end
`ifdef MUX16_SER_PARITY_EN
      PARITY: begin
        if (xfer) state_d = load ? SHIFT : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (load) begin
      word_d = in_data;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      word_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      active_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux16_word_serializer.sv
// Scoreboard bench: LSB-first and MSB-first instances share stimulus; each
// accepted word queues its expected beats, a negedge monitor pops and compares.
module tb_mux16_word_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        ser_ready;

  logic ir0, sv0, sd0, sf0, sl0, bz0;
  logic ir1, sv1, sd1, sf1, sl1, bz1;

  always #5 clk = ~clk;

  mux16_word_serializer #(.MSB_FIRST(1'b0), .WORD_W(16)) u_lsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (ir0),
    .in_data   (in_data),
    .ser_valid (sv0),
    .ser_ready (ser_ready),
    .ser_data  (sd0),
    .ser_first (sf0),
    .ser_last  (sl0),
    .busy      (bz0)
  );

  mux16_word_serializer #(.MSB_FIRST(1'b1), .WORD_W(16)) u_msb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (ir1),
    .in_data   (in_data),
    .ser_valid (sv1),
    .ser_ready (ser_ready),
    .ser_data  (sd1),
    .ser_first (sf1),
    .ser_last  (sl1),
    .busy      (bz1)
  );

`ifdef MUX16_SER_PARITY_EN
  localparam bit Par = 1'b1;
`else
  localparam bit Par = 1'b0;
`endif

  typedef struct packed {
    logic d;
    logic f;
    logic l;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  int    total = 0;
  int    bad   = 0;
  bit    chk_en = 1'b0;

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_word(input logic [15:0] w);
    beat_t b;
    for (int i = 0; i < 16; i++) begin
      b.f = (i == 0);
      b.l = (i == 15) && !Par;
      b.d = w[i];
      q0.push_back(b);
      b.d = w[15-i];
      q1.push_back(b);
    end
    if (Par) begin
      b.d = ^w;
      b.f = 1'b0;
      b.l = 1'b1;
      q0.push_back(b);
      q1.push_back(b);
    end
  endfunction

  task automatic mon(input int lane, input string tag, input logic sv, input logic sd,
                     input logic sf, input logic sl, input logic bz, input logic ir);
    beat_t h;
    bit    has;
    has = (lane == 0) ? (q0.size() > 0) : (q1.size() > 0);
    chk({tag, ".ser_valid"}, sv, has);
    chk({tag, ".busy"}, bz, has);
    if (has) begin
      h = (lane == 0) ? q0[0] : q1[0];
      chk({tag, ".ser_data"}, sd, h.d);
      chk({tag, ".ser_first"}, sf, h.f);
      chk({tag, ".ser_last"}, sl, h.l);
      chk({tag, ".in_ready_busy"}, ir, ser_ready & h.l);
      if (ser_ready) begin
        if (lane == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
      end
    end else begin
      chk({tag, ".idle_data"}, sd, 1'b0);
      chk({tag, ".idle_first"}, sf, 1'b0);
      chk({tag, ".idle_last"}, sl, 1'b0);
      chk({tag, ".idle_in_ready"}, ir, 1'b1);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      mon(0, "lsb", sv0, sd0, sf0, sl0, bz0, ir0);
      mon(1, "msb", sv1, sd1, sf1, sl1, bz1, ir1);
    end
  end

  // Offers w until accepted; expected beats are queued right after the accepting edge.
  task automatic send(input logic [15:0] w, input bit keep);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!ir0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ir0) begin
      chk("send.in_ready_wait", ir0, 1'b1);
    end else begin
      @(posedge clk);
      push_word(w);
      #1;
    end
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain.queue_empty", (q0.size() == 0) && (q1.size() == 0), 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".lsb_ser_valid"}, sv0, 1'b0);
    chk({tag, ".lsb_busy"}, bz0, 1'b0);
    chk({tag, ".lsb_ser_data"}, sd0, 1'b0);
    chk({tag, ".lsb_ser_first"}, sf0, 1'b0);
    chk({tag, ".lsb_ser_last"}, sl0, 1'b0);
    chk({tag, ".lsb_in_ready"}, ir0, 1'b0);
    chk({tag, ".msb_ser_valid"}, sv1, 1'b0);
    chk({tag, ".msb_busy"}, bz1, 1'b0);
    chk({tag, ".msb_ser_data"}, sd1, 1'b0);
    chk({tag, ".msb_in_ready"}, ir1, 1'b0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    ser_ready = 1'b1;
    #12;
    chk_reset_outputs("reset");
    release_reset();

    // Bit order: LSB lane expects 1100001110100101.
    send(16'hA5C3, 1'b0);
    drain();
    // MSB lane: 1, fourteen 0s, 1.
    send(16'h8001, 1'b0);
    drain();

    // Backpressure for 3 cycles while beat 5 is presented.
    send(16'h00FF, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    ser_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    ser_ready = 1'b1;
    drain();

    // Back-to-back frames with in_valid held throughout.
    send(16'hFFFF, 1'b1);
    send(16'h0000, 1'b0);
    drain();

    // Asynchronous reset while beat 7 (a 1 on the LSB lane) is presented.
    send(16'h0080, 1'b0);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    chk("midreset.pre_lsb_data", sd0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_en = 1'b0;
    chk_reset_outputs("midreset");
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    release_reset();
    send(16'h0001, 1'b0);
    drain();

    // Parity words (17-beat frames when the parity beat is built in).
    send(16'h0007, 1'b0);
    drain();
    send(16'h0003, 1'b0);
    drain();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux16_word_serializer.md
Name: mux16_word_serializer

Overview:
- Upstream sequencing stage for the 16-to-1 bit-select mux (`mux16to1`).
- Accepts a 16-bit word on a valid/ready handshake and holds it in a register.
- Steps a 4-bit counter that drives the mux select, so the word is emitted as a 16-beat serial stream with its own valid/ready handshake.
- Sits between a parallel word producer and a bit-serial consumer (link or shift interface).

Parameters:
- MSB_FIRST, default 0: 0 = bit 0 emitted first; 1 = bit 15 emitted first.
- WORD_W, default 16: fixed at 16, because the mux stage is 16:1. Any other value is a compile-time error.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  16  parallel word.
- ser_valid  output  1  ser_data is valid.
- ser_ready  input  1  downstream accepts the current bit.
- ser_data  output  1  current serial bit (output of the mux16to1 instance).
- ser_first  output  1  marks beat 0 of a frame.
- ser_last  output  1  marks the final beat of a frame.
- busy  output  1  a frame is in progress (state is not IDLE).

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are driven 0 immediately.
  - State = IDLE; word_q = 0; cnt = 0.
  - ser_valid, ser_first, ser_last, busy, ser_data = 0; in_ready = 0.
- Release: first rising edge with rst_n high enters normal operation; in_ready = 1 in IDLE.
- Mux select: sel = MSB_FIRST ? ~cnt : cnt.
- Output gating: ser_data = mux16to1(word_q, sel) gated by ser_valid, so it is 0 in IDLE.
- States:
  - IDLE: in_ready = 1, ser_valid = 0. On in_valid & in_ready: word_q <= in_data, cnt <= 0, go to SHIFT.
  - SHIFT: ser_valid = 1, ser_first = (cnt == 0), ser_last = (cnt == 15) when the optional feature is disabled.
    - On ser_valid & ser_ready: cnt <= cnt + 1. The 4-bit counter wraps 15 -> 0 naturally.
    - Transfer at cnt == 15, feature disabled: if in_valid, load the new word, cnt <= 0 and stay in SHIFT (zero-bubble back-to-back); otherwise go to IDLE.
  - PARITY: exists only with the optional feature (see below).
- in_ready is combinational: (state == IDLE) | (final-beat transfer this cycle, i.e. ser_valid & ser_ready & ser_last).
  - This creates a ser_ready -> in_ready combinational path, which is accepted by design.
- Latency: word accepted at edge N; its first bit is presented with ser_valid high in the cycle after edge N.
- Throughput: one bit per cycle with ser_ready held high; 16 cycles per word.
- Stall: with ser_ready low, word_q, cnt, ser_data, ser_first and ser_last hold stable. ser_valid never drops mid-frame.
- in_valid during a frame is ignored (in_ready = 0) except in the final-beat transfer cycle.
- Reset mid-frame: the partial word is discarded and ser_valid drops asynchronously. The next frame after release starts at beat 0 with ser_first = 1.

Optional Feature:
- Macro: MUX16_SER_PARITY_EN.
- Defined:
  - After the cnt == 15 transfer, the block enters state PARITY and emits one extra beat: ser_data = ^word_q (even parity), ser_last = 1, ser_first = 0.
  - ser_last is 0 on the data beat at cnt == 15.
  - Back-to-back load happens on the PARITY transfer instead.
  - Frame length is 17 beats.
- Undefined: the PARITY state and its logic are absent; frame length is 16 beats.

Decomposition:
- Shared package: state encoding typedef (IDLE, SHIFT, PARITY), constants WORD_W = 16 and SEL_W = 4, and the last-index constant 15.
- Sub-module: one instance of the existing mux16to1 as the bit-select datapath. The counter, FSM and handshake logic stay inline in this block.

Test Plan:
- Bit order, MSB_FIRST=0: reset, then in_data = 16'hA5C3 with ser_ready = 1 -> ser_data sequence 1100001110100101. ser_first is high on beat 0 only, ser_last on beat 15 only, in_ready = 0 on beats 0-14.
- MSB_FIRST=1: in_data = 16'h8001 -> 1, then fourteen 0s, then 1. First bit appears the cycle after acceptance.
- Backpressure: 16'h00FF with ser_ready = 0 for 3 cycles at beat 5 -> ser_data, ser_first, ser_last and cnt hold stable; exactly 16 transfers in total, with no bit lost or duplicated.
- Back-to-back: in_valid held with 16'hFFFF then 16'h0000 -> 32 consecutive ser_valid beats (16 ones, then 16 zeros) with no bubble. in_ready is high only in the beat-15 transfer cycle.
- Reset mid-frame: drive rst_n low asynchronously at beat 7 -> ser_valid, busy and ser_data go to 0 immediately. After release, in_data = 16'h0001 yields ser_first = 1 with ser_data = 1 on the first beat.
- With MUX16_SER_PARITY_EN: 16'h0007 -> 17 beats, beat 16 = 1, ser_last only on beat 16. With 16'h0003 -> beat 16 = 0.
